// File: rtl/branch_resolve_btb_if.sv
// Fetch-side BTB lookup and resolve-stage signals for branch_resolve_btb.
// The slave modport is the resolver; the master modport is the pipeline driving it.
interface branch_resolve_btb_if #(
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 32
);
  logic [NB_ADDR-1:0] i_fetch_pc;
  logic               o_pred_taken;
  logic [NB_ADDR-1:0] o_pred_target;

  logic               i_valid;
  logic [NB_ADDR-1:0] i_pc;
  logic [NB_WORD-1:0] i_instruction;
  logic [NB_WORD-1:0] i_op1;
  logic [NB_WORD-1:0] i_op2;
  logic               i_pred_taken;
  logic [NB_ADDR-1:0] i_pred_target;

  logic               o_valid;
  logic               o_branch_taken;
  logic [NB_ADDR-1:0] o_branch_addr;
  logic               o_mispredict;
  logic [NB_ADDR-1:0] o_ret_addr;
  logic               o_wr_retaddr;
  logic [4:0]         o_rd_retaddr;
  logic               o_flush;

  modport master (
    output i_fetch_pc, i_valid, i_pc, i_instruction, i_op1, i_op2,
           i_pred_taken, i_pred_target,
    input  o_pred_taken, o_pred_target, o_valid, o_branch_taken, o_branch_addr,
           o_mispredict, o_ret_addr, o_wr_retaddr, o_rd_retaddr, o_flush
  );

  modport slave (
    input  i_fetch_pc, i_valid, i_pc, i_instruction, i_op1, i_op2,
           i_pred_taken, i_pred_target,
    output o_pred_taken, o_pred_target, o_valid, o_branch_taken, o_branch_addr,
           o_mispredict, o_ret_addr, o_wr_retaddr, o_rd_retaddr, o_flush
  );
endinterface

// File: rtl/branch_resolve_btb.sv
// RV32I branch/jump resolver with a direct-mapped BTB (2-bit counters) and a
// down-counting flush timer that squashes younger instructions after a redirect.
module branch_resolve_btb #(
  parameter int NB_WORD      = 32,
  parameter int NB_ADDR      = 32,
  parameter int BTB_DEPTH    = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                 i_clock,
  input logic                 i_reset,
  branch_resolve_btb_if.slave bus
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic               btb_valid [BTB_DEPTH];
  logic [1:0]         btb_ctr   [BTB_DEPTH];
  logic [NB_ADDR-1:0] btb_tgt   [BTB_DEPTH];

  logic [IDX_W-1:0]   fetch_idx;
  logic [IDX_W-1:0]   upd_idx;
  logic [NB_ADDR-1:0] inst_addr;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [4:0]         rd;
  logic [NB_ADDR-1:0] imm_b, imm_j, imm_i;
  logic [NB_ADDR-1:0] tgt_branch, tgt_jal, jalr_sum, tgt_jalr;

  logic               is_branch, is_jump, taken, mispredict, accept;
  logic [NB_ADDR-1:0] target, next_addr;
  logic [1:0]         ctr_next;
  logic [FC_W-1:0]    flush_cnt;

  logic               valid_q, taken_q, mp_q, wr_q;
  logic [NB_ADDR-1:0] addr_q, ret_q;
  logic [4:0]         rd_q;

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign fetch_idx         = bus.i_fetch_pc[IDX_W+1:2];
  assign bus.o_pred_taken  = btb_valid[fetch_idx] & btb_ctr[fetch_idx][1];
  assign bus.o_pred_target = btb_tgt[fetch_idx];

  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{bus.i_fetch_pc[NB_ADDR-1:IDX_W+2], bus.i_fetch_pc[1:0]};

  assign inst_addr = bus.i_pc - NB_ADDR'(4);
  assign upd_idx   = inst_addr[IDX_W+1:2];
  assign opcode    = bus.i_instruction[6:0];
  assign funct3    = bus.i_instruction[14:12];
  assign rd        = bus.i_instruction[11:7];

  assign imm_b = {{(NB_ADDR-13){bus.i_instruction[31]}}, bus.i_instruction[31],
                  bus.i_instruction[7], bus.i_instruction[30:25],
                  bus.i_instruction[11:8], 1'b0};
  assign imm_j = {{(NB_ADDR-21){bus.i_instruction[31]}}, bus.i_instruction[31],
                  bus.i_instruction[19:12], bus.i_instruction[20],
                  bus.i_instruction[30:21], 1'b0};
  assign imm_i = {{(NB_ADDR-12){bus.i_instruction[31]}}, bus.i_instruction[31:20]};

  assign tgt_branch = inst_addr + imm_b;
  assign tgt_jal    = inst_addr + imm_j;
  assign jalr_sum   = NB_ADDR'(bus.i_op1) + imm_i;
  assign tgt_jalr   = jalr_sum & ~{{(NB_ADDR-1){1'b0}}, 1'b1};

  always_comb begin
    is_branch = 1'b0;
    is_jump   = 1'b0;
    taken     = 1'b0;
    target    = '0;
    case (opcode)
      OP_BRANCH: begin
        target    = tgt_branch;
        is_branch = 1'b1;
        case (funct3)
          3'b000:  taken = (bus.i_op1 == bus.i_op2);
          3'b001:  taken = (bus.i_op1 != bus.i_op2);
          3'b100:  taken = ($signed(bus.i_op1) <  $signed(bus.i_op2));
          3'b101:  taken = ($signed(bus.i_op1) >= $signed(bus.i_op2));
          3'b110:  taken = (bus.i_op1 <  bus.i_op2);
          3'b111:  taken = (bus.i_op1 >= bus.i_op2);
          default: is_branch = 1'b0;
        endcase
      end
      OP_JAL: begin
        is_jump = 1'b1;
        taken   = 1'b1;
        target  = tgt_jal;
      end
      OP_JALR: begin
        is_jump = 1'b1;
        taken   = 1'b1;
        target  = tgt_jalr;
      end
      default: ;
    endcase
  end

  // Reserved branch encodings fall into the last arm: they behave as non-branches.
  always_comb begin
    if (is_jump)
      mispredict = !(bus.i_pred_taken && (bus.i_pred_target == target));
    else if (is_branch)
      mispredict = (taken != bus.i_pred_taken) ||
                   (taken && (bus.i_pred_target != target));
    else
      mispredict = bus.i_pred_taken;
  end

  assign next_addr = taken ? target : bus.i_pc;
  assign accept    = bus.i_valid && (flush_cnt == '0);

  always_comb begin
    ctr_next = btb_ctr[upd_idx];
    if (taken && btb_ctr[upd_idx] != 2'b11)
      ctr_next = btb_ctr[upd_idx] + 2'b01;
    else if (!taken && btb_ctr[upd_idx] != 2'b00)
      ctr_next = btb_ctr[upd_idx] - 2'b01;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= 2'b01;
        btb_tgt[i]   <= '0;
      end
    end else if (accept) begin
      if (is_branch) begin
        btb_valid[upd_idx] <= 1'b1;
        btb_ctr[upd_idx]   <= ctr_next;
        if (taken)
          btb_tgt[upd_idx] <= target;
      end else if (is_jump) begin
        btb_valid[upd_idx] <= 1'b1;
        btb_ctr[upd_idx]   <= 2'b11;
        btb_tgt[upd_idx]   <= target;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      addr_q  <= '0;
      mp_q    <= 1'b0;
      ret_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      valid_q <= accept;
      taken_q <= accept && taken;
      addr_q  <= accept ? next_addr : '0;
      mp_q    <= accept && mispredict;
      ret_q   <= (accept && is_jump) ? bus.i_pc : '0;
      wr_q    <= accept && is_jump;
      rd_q    <= (accept && is_jump) ? rd : '0;
    end
  end

  // Flush timer loads alongside the registered mispredict and counts down to zero.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      flush_cnt <= '0;
    else if (accept && mispredict)
      flush_cnt <= FC_W'(FLUSH_CYCLES);
    else if (flush_cnt != '0)
      flush_cnt <= flush_cnt - FC_W'(1);
  end

  assign bus.o_valid        = valid_q;
  assign bus.o_branch_taken = taken_q;
  assign bus.o_branch_addr  = addr_q;
  assign bus.o_mispredict   = mp_q;
  assign bus.o_ret_addr     = ret_q;
  assign bus.o_wr_retaddr   = wr_q;
  assign bus.o_rd_retaddr   = rd_q;
  assign bus.o_flush        = (flush_cnt != '0);

endmodule

// File: tb/tb_branch_resolve_btb.sv
// Directed and randomized checks of branch_resolve_btb against a behavioural
// model that works from instruction kind/immediate fields rather than bit decode.
module tb_branch_resolve_btb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_btb_if #(.NB_WORD(32), .NB_ADDR(32)) bus ();

  branch_resolve_btb #(
    .NB_WORD(32), .NB_ADDR(32), .BTB_DEPTH(64), .FLUSH_CYCLES(2)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  bit          mvalid [64];
  int          mctr   [64];
  logic [31:0] mtgt   [64];
  int          mcnt;

  // kind: 0 branch, 1 JAL, 2 JALR, 3 other (ADDI)
  bit          cur_valid;
  int          cur_kind, cur_f3, cur_imm, cur_rd;
  logic [31:0] cur_op1, cur_op2, cur_pc, cur_ptgt;
  bit          cur_pt;

  int slot_bimm [32];
  int slot_jimm [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encode(input int kind, input int f3, input int imm, input int rd);
    logic [20:0] im;
    logic [2:0]  f;
    logic [4:0]  r;
    im = imm[20:0];
    f  = f3[2:0];
    r  = rd[4:0];
    case (kind)
      0:       return {im[12], im[10:5], 5'd2, 5'd1, f, im[4:1], im[11], 7'b1100011};
      1:       return {im[20], im[10:1], im[11], im[19:12], r, 7'b1101111};
      2:       return {im[11:0], 5'd1, 3'b000, r, 7'b1100111};
      default: return {12'h005, 5'd3, 3'b000, r, 7'b0010011};
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr / 4) % 64);
  endfunction

  task automatic mreset();
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0;
      mctr[i]   = 1;
      mtgt[i]   = '0;
    end
    mcnt = 0;
  endtask

  task automatic drive();
    bus.i_valid       = cur_valid;
    bus.i_pc          = cur_pc;
    bus.i_instruction = encode(cur_kind, cur_f3, cur_imm, cur_rd);
    bus.i_op1         = cur_op1;
    bus.i_op2         = cur_op2;
    bus.i_pred_taken  = cur_pt;
    bus.i_pred_target = cur_ptgt;
  endtask

  task automatic set_instr(input int kind, input int f3, input int imm, input int rd,
                           input logic [31:0] op1, input logic [31:0] op2,
                           input logic [31:0] pc, input bit pt, input logic [31:0] ptgt);
    cur_valid = 1'b1;
    cur_kind  = kind;
    cur_f3    = f3;
    cur_imm   = imm;
    cur_rd    = rd;
    cur_op1   = op1;
    cur_op2   = op2;
    cur_pc    = pc;
    cur_pt    = pt;
    cur_ptgt  = ptgt;
    drive();
  endtask

  task automatic idle();
    cur_valid = 1'b0;
    drive();
  endtask

  task automatic chk_lookup(input logic [31:0] pc);
    int i;
    bus.i_fetch_pc = pc;
    #1;
    i = idx_of(pc);
    chk("pred_taken", {31'd0, bus.o_pred_taken}, {31'd0, mvalid[i] && mctr[i] >= 2});
    chk("pred_target", bus.o_pred_target, mtgt[i]);
  endtask

  // Advance one clock: predict what the resolver must register from the
  // presented instruction, update the model, then compare after the edge.
  task automatic cycle();
    logic [31:0] a, tgt, e_addr, e_ret;
    bit acc, tk, mp, legal, wr;
    int e_rd, i;
    acc = cur_valid && (mcnt == 0);
    a = cur_pc - 32'd4;
    i = idx_of(a);
    tk = 0; mp = 0; legal = 0; wr = 0; tgt = '0; e_rd = 0; e_ret = '0;
    case (cur_kind)
      0: begin
        tgt = a + 32'(cur_imm);
        legal = !(cur_f3 == 2 || cur_f3 == 3);
        case (cur_f3)
          0: tk = (cur_op1 == cur_op2);
          1: tk = (cur_op1 != cur_op2);
          4: tk = ($signed(cur_op1) < $signed(cur_op2));
          5: tk = ($signed(cur_op1) >= $signed(cur_op2));
          6: tk = (cur_op1 < cur_op2);
          7: tk = (cur_op1 >= cur_op2);
          default: tk = 0;
        endcase
        if (legal) mp = (tk != cur_pt) || (tk && cur_pt && cur_ptgt != tgt);
        else       mp = cur_pt;
      end
      1, 2: begin
        if (cur_kind == 1) tgt = a + 32'(cur_imm);
        else               tgt = (cur_op1 + 32'(cur_imm)) & ~32'd1;
        tk = 1; wr = 1; e_rd = cur_rd; e_ret = cur_pc;
        mp = !(cur_pt && cur_ptgt == tgt);
      end
      default: mp = cur_pt;
    endcase
    e_addr = tk ? tgt : cur_pc;
    if (acc) begin
      if (cur_kind == 0 && legal) begin
        mvalid[i] = 1;
        mctr[i] = tk ? ((mctr[i] < 3) ? mctr[i] + 1 : 3) : ((mctr[i] > 0) ? mctr[i] - 1 : 0);
        if (tk) mtgt[i] = tgt;
      end else if (cur_kind == 1 || cur_kind == 2) begin
        mvalid[i] = 1; mctr[i] = 3; mtgt[i] = tgt;
      end
    end
    if (acc && mp)  mcnt = 2;
    else if (mcnt > 0) mcnt--;
    @(posedge clk);
    #1;
    chk("o_valid",        {31'd0, bus.o_valid},        {31'd0, acc});
    chk("o_branch_taken", {31'd0, bus.o_branch_taken}, {31'd0, acc && tk});
    chk("o_branch_addr",  bus.o_branch_addr,           acc ? e_addr : 32'd0);
    chk("o_mispredict",   {31'd0, bus.o_mispredict},   {31'd0, acc && mp});
    chk("o_ret_addr",     bus.o_ret_addr,              acc ? e_ret : 32'd0);
    chk("o_wr_retaddr",   {31'd0, bus.o_wr_retaddr},   {31'd0, acc && wr});
    chk("o_rd_retaddr",   {27'd0, bus.o_rd_retaddr},   acc ? 32'(e_rd) : 32'd0);
    chk("o_flush",        {31'd0, bus.o_flush},        {31'd0, mcnt != 0});
  endtask

  initial begin
    mreset();
    cur_kind = 3; cur_f3 = 0; cur_imm = 0; cur_rd = 0;
    cur_op1 = '0; cur_op2 = '0; cur_pc = '0; cur_pt = 0; cur_ptgt = '0;
    bus.i_fetch_pc = '0;
    idle();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_flush", {31'd0, bus.o_flush}, 32'd0);
    chk("rst_addr", bus.o_branch_addr, 32'd0);
    chk_lookup(32'h100);

    // first edge after reset release accepts a taken BEQ predicted not-taken
    rst_n = 1'b1;
    set_instr(0, 0, 16, 0, 32'd5, 32'd5, 32'h104, 0, 32'd0);
    cycle();
    chk("beq_addr", bus.o_branch_addr, 32'h110);
    chk("beq_mp", {31'd0, bus.o_mispredict}, 32'd1);
    idle();
    cycle();
    chk("beq_flush2", {31'd0, bus.o_flush}, 32'd1);
    cycle();
    chk("beq_flush_end", {31'd0, bus.o_flush}, 32'd0);
    chk_lookup(32'h100);
    chk("beq_pred", {31'd0, bus.o_pred_taken}, 32'd1);
    chk("beq_tgt", bus.o_pred_target, 32'h110);

    // counter saturates then steps down once on a not-taken outcome
    set_instr(0, 0, 16, 0, 32'd5, 32'd5, 32'h104, 1, 32'h110);
    cycle();
    cycle();
    chk("sat_no_mp", {31'd0, bus.o_mispredict}, 32'd0);
    set_instr(0, 0, 16, 0, 32'd1, 32'd2, 32'h104, 1, 32'h110);
    cycle();
    chk("nt_addr", bus.o_branch_addr, 32'h104);
    idle();
    chk_lookup(32'h100);
    chk("nt_pred_kept", {31'd0, bus.o_pred_taken}, 32'd1);
    cycle();
    cycle();

    // JALR with correct prediction and link
    set_instr(2, 0, 4, 1, 32'h2003, 32'd0, 32'h204, 1, 32'h2006);
    cycle();
    chk("jalr_addr", bus.o_branch_addr, 32'h2006);
    chk("jalr_ret", bus.o_ret_addr, 32'h204);
    chk("jalr_rd", {27'd0, bus.o_rd_retaddr}, 32'd1);

    // signed vs unsigned compare
    set_instr(0, 4, 32, 0, 32'hFFFF_FFFF, 32'd1, 32'h308, 1, 32'h324);
    cycle();
    chk("blt_taken", {31'd0, bus.o_branch_taken}, 32'd1);
    set_instr(0, 6, 32, 0, 32'hFFFF_FFFF, 32'd1, 32'h30C, 0, 32'd0);
    cycle();
    chk("bltu_taken", {31'd0, bus.o_branch_taken}, 32'd0);

    // two squashed instructions behind a mispredict, third accepted
    set_instr(0, 1, 8, 0, 32'd1, 32'd2, 32'h404, 0, 32'd0);
    cycle();
    set_instr(1, 0, 256, 5, 32'd0, 32'd0, 32'h504, 0, 32'd0);
    cycle();
    chk("squash1", {31'd0, bus.o_valid}, 32'd0);
    cycle();
    chk("squash2", {31'd0, bus.o_valid}, 32'd0);
    chk_lookup(32'h500);
    cycle();
    chk("third_accept", {31'd0, bus.o_valid}, 32'd1);
    idle();

    // reset in the middle of the flush
    rst_n = 1'b0;
    #1;
    chk("midrst_flush", {31'd0, bus.o_flush}, 32'd0);
    chk("midrst_valid", {31'd0, bus.o_valid}, 32'd0);
    mreset();
    for (int k = 0; k < 8; k++) chk_lookup(32'(k * 32 + 4));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized traffic with per-slot immediates so repeats predict well
    for (int s = 0; s < 32; s++) begin
      slot_bimm[s] = (int'($urandom_range(0, 4095)) - 2048) * 2;
      slot_jimm[s] = (int'($urandom_range(0, 1048575)) - 524288) * 2;
    end
    for (int n = 0; n < 400; n++) begin
      int s, r, kind, f3, imm, i;
      logic [31:0] pc, op1, op2, ptgt;
      bit pt;
      s = int'($urandom_range(0, 31));
      pc = 32'(s % 16) * 4 + 4 + ((s >= 16) ? 32'h1000 : 32'h0);
      r = int'($urandom_range(0, 9));
      kind = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
      f3 = int'($urandom_range(0, 7));
      imm = (kind == 0) ? slot_bimm[s] : (kind == 1) ? slot_jimm[s]
          : int'($urandom_range(0, 4095)) - 2048;
      op1 = $urandom;
      op2 = ($urandom_range(0, 1) == 1) ? op1 : $urandom;
      if ($urandom_range(0, 3) == 0) op2 = 32'($urandom_range(0, 3));
      i = idx_of(pc - 32'd4);
      if ($urandom_range(0, 2) != 0) begin
        pt = mvalid[i] && mctr[i] >= 2;
        ptgt = mtgt[i];
      end else begin
        pt = 1'($urandom_range(0, 1));
        ptgt = $urandom & ~32'd1;
      end
      set_instr(kind, f3, imm, int'($urandom_range(0, 31)), op1, op2, pc, pt, ptgt);
      if ($urandom_range(0, 9) < 2) idle();
      cycle();
      chk_lookup(32'($urandom_range(0, 127)) * 4);
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
